// File: rtl/md_ctrl_if.sv
// Handshake and HI/LO bus between the main control FSM (master) and md_ctrl (slave).
interface md_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic [1:0]       md_op;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, md_op, op_a, op_b, hi_we, lo_we, wr_data,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, md_op, op_a, op_b, hi_we, lo_we, wr_data,
    output busy, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/md_ctrl.sv
// Iterative multiply/divide unit owning HI/LO: shift-add multiply, restoring divide, one bit per cycle.
// Define MD_DIV_EN to build the divider; otherwise div/divu finish at once flagged via div_by_zero.
module md_ctrl #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      rst,
  md_ctrl_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_next;
  logic [CW-1:0]      count;
  logic               sign_a_q, sign_b_q, dz_q;
  logic [WIDTH-1:0]   mag_a_q;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   hi_q, lo_q, res_hi, res_lo;
  logic               done_q, dz_out_q;

  logic               in_signed, in_div, in_sign_a, in_sign_b, reject;
  logic [WIDTH-1:0]   in_mag_a, in_mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;

`ifdef MD_DIV_EN
  logic               div_q;
  logic [WIDTH-1:0]   mag_b_q;
  logic [WIDTH+1:0]   trial;
`endif

  // Operand decode: signed ops take two's-complement magnitudes.
  always_comb begin
    in_signed = ~bus.md_op[0];
    in_div    = bus.md_op[1];
    in_sign_a = in_signed & bus.op_a[WIDTH-1];
    in_sign_b = in_signed & bus.op_b[WIDTH-1];
    in_mag_a  = in_sign_a ? -bus.op_a : bus.op_a;
    in_mag_b  = in_sign_b ? -bus.op_b : bus.op_b;
`ifdef MD_DIV_EN
    reject    = in_div && (bus.op_b == '0);
`else
    reject    = in_div;
`endif
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = reject ? FIX : RUN;
      RUN:     if (count == CW'(WIDTH - 1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multiply step: add multiplicand to the upper half when the low multiplier bit is set, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a_q} : '0);
    acc_next = {mul_sum, acc[WIDTH-1:1]};
`ifdef MD_DIV_EN
    // Restoring divide step: upper half is the partial remainder, lower half shifts dividend out / quotient in.
    trial = {1'b0, acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {2'b00, mag_b_q};
    if (div_q) begin
      acc_next = trial[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
`endif
  end

  // Sign correction applied during FIX.
  always_comb begin
    prod   = (sign_a_q ^ sign_b_q) ? -acc : acc;
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
`ifdef MD_DIV_EN
    if (div_q) begin
      res_lo = (sign_a_q ^ sign_b_q) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      res_hi = sign_a_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      dz_q     <= 1'b0;
      mag_a_q  <= '0;
      acc      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_out_q <= 1'b0;
`ifdef MD_DIV_EN
      div_q    <= 1'b0;
      mag_b_q  <= '0;
`endif
    end else begin
      done_q   <= (state == FIX);
      dz_out_q <= (state == FIX) && dz_q;
      case (state)
        IDLE: begin
          if (bus.hi_we) hi_q <= bus.wr_data;
          if (bus.lo_we) lo_q <= bus.wr_data;
          if (bus.start) begin
            sign_a_q <= in_sign_a;
            sign_b_q <= in_sign_b;
            mag_a_q  <= in_mag_a;
            dz_q     <= reject;
            count    <= '0;
            acc      <= {{WIDTH{1'b0}}, in_mag_b};
`ifdef MD_DIV_EN
            div_q    <= in_div;
            mag_b_q  <= in_mag_b;
            if (in_div) acc <= {{WIDTH{1'b0}}, in_mag_a};
`endif
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count + CW'(1);
        end
        FIX: begin
          if (!dz_q) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.div_by_zero = dz_out_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed self-checking bench for md_ctrl; divide expectations follow the MD_DIV_EN build option.
module tb_md_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  md_ctrl_if #(.WIDTH(32)) bus ();

  md_ctrl #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one operation, optionally poke start/hi_we mid-run, and check result, latency and pulse shape.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edz, input int elat, input bit inject);
    int k;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.op_a = a; bus.op_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    k = 0;
    while (!bus.done && k < 100) begin
      if (inject && k == 5) begin
        bus.start = 1'b1; bus.md_op = 2'b00; bus.op_a = 32'd3; bus.op_b = 32'd3;
        bus.hi_we = 1'b1; bus.wr_data = 32'h0000DEAD;
      end
      if (inject && k == 6) begin
        bus.start = 1'b0; bus.hi_we = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    check({tag, "_lat"}, k, elat);
    check({tag, "_dz"}, {31'd0, bus.div_by_zero}, {31'd0, edz});
    check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_hi"}, bus.hi, ehi);
    check({tag, "_lo"}, bus.lo, elo);
    @(negedge clk);
    check({tag, "_pulse"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    bit saw_done;
    bus.start = 1'b0; bus.md_op = 2'b00; bus.op_a = '0; bus.op_b = '0;
    bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wr_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_dz", {31'd0, bus.div_by_zero}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);

    run_op("mult_neg", 2'b00, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, 1'b0);
    run_op("multu", 2'b01, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33, 1'b0);

`ifdef MD_DIV_EN
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b0);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, 33, 1'b0);
`else
    run_op("div_neg", 2'b10, 32'hFFFFFFF9, 32'h2, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1, 1'b0);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1, 1'b0);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b1, 1, 1'b0);
`endif

    // Preload HI/LO, then a zero divide must leave them untouched.
    @(negedge clk);
    bus.hi_we = 1'b1; bus.wr_data = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b1; bus.wr_data = 32'h5678;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mthi_pre", bus.hi, 32'h1234);
    check("mtlo_pre", bus.lo, 32'h5678);
    run_op("divu_zero", 2'b11, 32'd5, 32'd0, 32'h1234, 32'h5678, 1'b1, 1, 1'b0);

    // Start and mthi while busy are both dropped.
    run_op("busy_ign", 2'b00, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33, 1'b1);
    check("no_requeue", {31'd0, bus.busy}, 32'd0);

    @(negedge clk);
    bus.hi_we = 1'b1; bus.wr_data = 32'hBEEF;
    @(negedge clk);
    bus.hi_we = 1'b0;
    check("mthi_idle", bus.hi, 32'hBEEF);
    check("mthi_lo_keep", bus.lo, 32'hFFFFFFFE);

    // Both enables together write the same data.
    @(negedge clk);
    bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wr_data = 32'hA5A5;
    @(negedge clk);
    bus.hi_we = 1'b0; bus.lo_we = 1'b0;
    check("both_hi", bus.hi, 32'hA5A5);
    check("both_lo", bus.lo, 32'hA5A5);

    // Reset mid-operation aborts with no done.
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 2'b01; bus.op_a = 32'hFFFFFFFF; bus.op_b = 32'h2;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);

    run_op("mult_fresh", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 33, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
